// File: rtl/spart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spart_pkg : shared SPART types and constants (tx and rx)  | rev 1.0  |
// +----------------------------------------------------------------------+
package spart_pkg;

   localparam int SPART_DATA_BITS            = 8;
   localparam int SPART_DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } spart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/spart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spart_tx_if : bus-side handshake and serial pin of spart_tx | rev 1.0 |
// +----------------------------------------------------------------------+
interface spart_tx_if;

   logic                                 tx_write;
   logic [spart_pkg::SPART_DATA_BITS-1:0] tx_data;
   logic                                 tbr;
   logic                                 tx;
   logic                                 tx_busy;

   modport master (
      output tx_write,
      output tx_data,
      input  tbr,
      input  tx,
      input  tx_busy
   );

   modport slave (
      input  tx_write,
      input  tx_data,
      output tbr,
      output tx,
      output tx_busy
   );

endinterface
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spart_baud_gen : bit-period counter, tick on last cycle    | rev 1.0  |
// +----------------------------------------------------------------------+
module spart_baud_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/spart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spart_tx : 8N1 transmitter with one-byte holding register | rev 1.0  |
// +----------------------------------------------------------------------+
module spart_tx
   import spart_pkg::*;
#(
   parameter int CLKS_PER_BIT = SPART_DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   spart_tx_if.slave  bus
);

   localparam int                 IW       = $clog2(SPART_DATA_BITS);
   localparam logic [IW-1:0]      LAST_BIT = IW'(SPART_DATA_BITS - 1);

   spart_tx_state_t              state_q, state_d;
   logic [SPART_DATA_BITS-1:0]   thr_q, thr_d;
   logic                         thr_full_q, thr_full_d;
   logic [SPART_DATA_BITS-1:0]   shift_q, shift_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic                         tx_q, tx_d;
   logic                         busy_q, busy_d;
   logic                         load;
   logic                         bit_tick;

   spart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (load || (state_q == IDLE)),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_d    = state_q;
      thr_d      = thr_q;
      thr_full_d = thr_full_q;
      shift_d    = shift_q;
      idx_d      = idx_q;
      load       = 1'b0;

      // A load needs a full THR, so it can never collide with an accepted write.
      if (bus.tx_write && !thr_full_q) begin
         thr_d      = bus.tx_data;
         thr_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (thr_full_q) load = 1'b1;
         end
         START: begin
            if (bit_tick) state_d = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               if (idx_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (thr_full_q) load = 1'b1;
               else            state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         shift_d    = thr_q;
         thr_full_d = 1'b0;
         idx_d      = '0;
         state_d    = START;
      end

      // Pin is registered from the next state so it changes with the state.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         thr_q      <= '0;
         thr_full_q <= 1'b0;
         shift_q    <= '0;
         idx_q      <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         thr_full_q <= thr_full_d;
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.tbr     = ~thr_full_q;
   assign bus.tx      = tx_q;
   assign bus.tx_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spart_tx : directed vector bench for spart_tx          | rev 1.0  |
// +----------------------------------------------------------------------+
module tb_spart_tx;

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [9:0] seq;   // seq[i] is the i-th bit on the wire, start bit first
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   spart_tx_if b4 ();
   spart_tx_if b2 ();

   spart_tx #(.CLKS_PER_BIT(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
   spart_tx #(.CLKS_PER_BIT(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic drive(input int sel, input logic wr, input logic [7:0] d);
      if (sel == 2) begin
         b2.tx_write = wr;
         b2.tx_data  = d;
      end else begin
         b4.tx_write = wr;
         b4.tx_data  = d;
      end
   endtask

   task automatic sample(input int sel, output logic tx, output logic tbr, output logic busy);
      if (sel == 2) begin
         tx = b2.tx; tbr = b2.tbr; busy = b2.tx_busy;
      end else begin
         tx = b4.tx; tbr = b4.tbr; busy = b4.tx_busy;
      end
   endtask

   // Returns on the falling edge just after the write edge N.
   task automatic write(input int sel, input logic [7:0] d, input string nm);
      logic tx, tbr, busy;
      @(negedge clk);
      drive(sel, 1'b1, d);
      @(negedge clk);
      drive(sel, 1'b0, 8'h00);
      sample(sel, tx, tbr, busy);
      chk({nm, " tbr_after_write"}, {7'd0, tbr}, 8'd0);
   endtask

   task automatic frames(input int sel, input string nm, input logic [19:0] seq, input int nfr,
                         input int wa_at, input logic [7:0] wa_d,
                         input int wb_at, input logic [7:0] wb_d);
      logic tx, tbr, busy;
      int   len;
      len = nfr * 10 * sel;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         sample(sel, tx, tbr, busy);
         chk({nm, " tx"}, {7'd0, tx}, {7'd0, seq[k / sel]});
         chk({nm, " busy"}, {7'd0, busy}, 8'd1);
         if (k == 0 || (nfr == 2 && k == 10 * sel))
            chk({nm, " tbr_at_load"}, {7'd0, tbr}, 8'd1);
         if (wa_at >= 0 && k == wa_at + 1)
            chk({nm, " tbr_queued"}, {7'd0, tbr}, 8'd0);
         if (k == wa_at)      drive(sel, 1'b1, wa_d);
         else if (k == wb_at) drive(sel, 1'b1, wb_d);
         else                 drive(sel, 1'b0, 8'h00);
      end
      drive(sel, 1'b0, 8'h00);
      @(negedge clk);
      sample(sel, tx, tbr, busy);
      chk({nm, " busy_end"}, {7'd0, busy}, 8'd0);
      chk({nm, " tx_end"},   {7'd0, tx},   8'd1);
      chk({nm, " tbr_end"},  {7'd0, tbr},  8'd1);
   endtask

   task automatic idle_check(input int sel, input string nm, input int n);
      logic tx, tbr, busy;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         sample(sel, tx, tbr, busy);
         chk({nm, " idle_tx"},   {7'd0, tx},   8'd1);
         chk({nm, " idle_busy"}, {7'd0, busy}, 8'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [7];
      logic tx, tbr, busy;

      vecs[0] = '{4, 8'hA5, 10'b1101001010};
      vecs[1] = '{4, 8'h00, 10'b1000000000};
      vecs[2] = '{4, 8'hFF, 10'b1111111110};
      vecs[3] = '{4, 8'h3C, 10'b1001111000};
      vecs[4] = '{2, 8'h80, 10'b1100000000};
      vecs[5] = '{2, 8'h01, 10'b1000000010};
      vecs[6] = '{2, 8'h5A, 10'b1010110100};

      // Power-up reset, with write pulses that must be ignored.
      rst = 1'b1;
      drive(4, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      @(negedge clk);
      drive(4, 1'b1, 8'hAA);
      drive(2, 1'b1, 8'hAA);
      @(negedge clk);
      drive(4, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      sample(4, tx, tbr, busy);
      chk("reset tbr", {7'd0, tbr}, 8'd1);
      chk("reset tx",  {7'd0, tx},  8'd1);
      chk("reset busy", {7'd0, busy}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      sample(2, tx, tbr, busy);
      chk("post_reset u2 tbr",  {7'd0, tbr},  8'd1);
      chk("post_reset u2 tx",   {7'd0, tx},   8'd1);
      chk("post_reset u2 busy", {7'd0, busy}, 8'd0);
      idle_check(4, "post_reset", 10);

      // Single-frame vectors on both baud settings.
      foreach (vecs[i]) begin
         write(vecs[i].sel, vecs[i].data, $sformatf("vec%0d", i));
         frames(vecs[i].sel, $sformatf("vec%0d", i), {10'd0, vecs[i].seq}, 1, -1, 8'h00, -1, 8'h00);
         idle_check(vecs[i].sel, $sformatf("vec%0d", i), 2);
      end

      // Back-to-back: second byte queued on the first frame cycle.
      write(4, 8'h55, "b2b");
      frames(4, "b2b", {10'b1000011110, 10'b1010101010}, 2, 0, 8'h0F, -1, 8'h00);
      idle_check(4, "b2b", 4);

      // Overrun: 0x33 arrives while the THR still holds 0x22.
      write(4, 8'h11, "ovr");
      frames(4, "ovr", {10'b1001000100, 10'b1000100010}, 2, 0, 8'h22, 2, 8'h33);
      idle_check(4, "ovr", 40);

      // Reset during data bit 3 of 0xF0.
      write(4, 8'hF0, "midrst");
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         sample(4, tx, tbr, busy);
         if (k == 16) chk("midrst bit3_tx", {7'd0, tx}, 8'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sample(4, tx, tbr, busy);
      chk("midrst tx",   {7'd0, tx},   8'd1);
      chk("midrst tbr",  {7'd0, tbr},  8'd1);
      chk("midrst busy", {7'd0, busy}, 8'd0);
      idle_check(4, "midrst", 50);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
